// File: rtl/lot_turn_if.sv
// Board-side and lottery-core-side signals of the turn controller.
interface lot_turn_if;
  logic       start;
  logic       btn;
  logic [3:0] num;
  logic [3:0] num_out;
  logic       insere;
  logic       fim;
  logic       fim_jogo;
  logic       player;
  logic [2:0] bet_cnt;
  logic       busy;
  logic       rej;
  logic       timeout_err;

  modport slave (
    input  start, btn, num,
    output num_out, insere, fim, fim_jogo, player, bet_cnt, busy, rej, timeout_err
  );

  modport master (
    output start, btn, num,
    input  num_out, insere, fim, fim_jogo, player, bet_cnt, busy, rej, timeout_err
  );
endinterface

// File: rtl/lot_turn_ctrl.sv
// Two-player lottery round sequencer: button edge capture, bet counting,
// per-turn timeout and the insere/fim/fim_jogo strobes for the core.
module lot_turn_ctrl #(
  parameter int NUM_BETS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  lot_turn_if.slave  lt
);
  typedef enum logic [1:0] {IDLE, TURN, ENDP, DONE} state_e;

  localparam logic [2:0] BETS = 3'(NUM_BETS);
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       btn_q;
  logic [7:0] timer_q, timer_d;
  logic [3:0] num_out_q, num_out_d;
  logic [2:0] bet_cnt_q, bet_cnt_d;
  logic       insere_q, insere_d, fim_q, fim_d, fim_jogo_q, fim_jogo_d;
  logic       player_q, player_d, busy_q, busy_d, rej_q, rej_d;
  logic       tmo_q, tmo_d;

  logic btn_rise, full_w, acc_w, bad_w, expire_w;

  // A full turn spends one more TURN cycle before ENDP, so fim trails the
  // last insere by one cycle; edges in that cycle are dropped.
  assign btn_rise = lt.btn & ~btn_q;
  assign full_w   = (bet_cnt_q == BETS);
  assign acc_w    = (state_q == TURN) && !full_w && btn_rise && (lt.num <= 4'd9);
  assign bad_w    = (state_q == TURN) && !full_w && btn_rise && (lt.num > 4'd9);
  assign expire_w = (state_q == TURN) && !full_w && !acc_w && (timer_q == TMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      btn_q      <= 1'b0;
      timer_q    <= 8'd0;
      num_out_q  <= 4'd0;
      bet_cnt_q  <= 3'd0;
      insere_q   <= 1'b0;
      fim_q      <= 1'b0;
      fim_jogo_q <= 1'b0;
      player_q   <= 1'b0;
      busy_q     <= 1'b0;
      rej_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= lt.btn;
      timer_q    <= timer_d;
      num_out_q  <= num_out_d;
      bet_cnt_q  <= bet_cnt_d;
      insere_q   <= insere_d;
      fim_q      <= fim_d;
      fim_jogo_q <= fim_jogo_d;
      player_q   <= player_d;
      busy_q     <= busy_d;
      rej_q      <= rej_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (lt.start) state_d = TURN;
      TURN: if (full_w || expire_w) state_d = ENDP;
      ENDP: state_d = player_q ? DONE : TURN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered alongside the state, so strobes tied to a state
  // are decoded from the next state.
  always_comb begin
    timer_d    = timer_q;
    num_out_d  = num_out_q;
    bet_cnt_d  = bet_cnt_q;
    player_d   = player_q;
    tmo_d      = tmo_q;
    insere_d   = acc_w;
    rej_d      = bad_w;
    fim_d      = (state_d == ENDP);
    fim_jogo_d = (state_d == DONE);
    busy_d     = (state_d != IDLE);
    case (state_q)
      IDLE: if (lt.start) begin
        player_d  = 1'b0;
        bet_cnt_d = 3'd0;
        timer_d   = 8'd0;
        tmo_d     = 1'b0;
      end
      TURN: begin
        if (acc_w) begin
          num_out_d = lt.num;
          bet_cnt_d = bet_cnt_q + 3'd1;
          timer_d   = 8'd0;
        end else if (expire_w) begin
          tmo_d = 1'b1;
        end else if (!full_w) begin
          timer_d = timer_q + 8'd1;
        end
      end
      ENDP: if (!player_q) begin
        player_d  = 1'b1;
        bet_cnt_d = 3'd0;
        timer_d   = 8'd0;
      end
      default: ;
    endcase
  end

  assign lt.num_out     = num_out_q;
  assign lt.insere      = insere_q;
  assign lt.fim         = fim_q;
  assign lt.fim_jogo    = fim_jogo_q;
  assign lt.player      = player_q;
  assign lt.bet_cnt     = bet_cnt_q;
  assign lt.busy        = busy_q;
  assign lt.rej         = rej_q;
  assign lt.timeout_err = tmo_q;
endmodule

// File: tb/tb_lot_turn_ctrl.sv
// Directed bench: dut_a (NUM_BETS=4, TIMEOUT=255), dut_b (NUM_BETS=4, TIMEOUT=10).
module tb_lot_turn_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   cnt;

  always #5 clk = ~clk;

  lot_turn_if ia();
  lot_turn_if ib();

  lot_turn_ctrl #(.NUM_BETS(4), .TIMEOUT(255)) dut_a (.clk(clk), .reset(rst), .lt(ia));
  lot_turn_ctrl #(.NUM_BETS(4), .TIMEOUT(10))  dut_b (.clk(clk), .reset(rst), .lt(ib));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press_a(input logic [3:0] v);
    ia.btn = 1'b1; ia.num = v;
    step();
    ia.btn = 1'b0;
  endtask

  task automatic press_b(input logic [3:0] v);
    ib.btn = 1'b1; ib.num = v;
    step();
    ib.btn = 1'b0;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, ".num_out"},  {4'd0, ia.num_out}, 8'd0);
    chk({tag, ".insere"},   {7'd0, ia.insere}, 8'd0);
    chk({tag, ".fim"},      {7'd0, ia.fim}, 8'd0);
    chk({tag, ".fim_jogo"}, {7'd0, ia.fim_jogo}, 8'd0);
    chk({tag, ".player"},   {7'd0, ia.player}, 8'd0);
    chk({tag, ".bet_cnt"},  {5'd0, ia.bet_cnt}, 8'd0);
    chk({tag, ".busy"},     {7'd0, ia.busy}, 8'd0);
    chk({tag, ".rej"},      {7'd0, ia.rej}, 8'd0);
    chk({tag, ".tmo"},      {7'd0, ia.timeout_err}, 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    ia.start = 1'b0; ia.btn = 1'b0; ia.num = 4'd0;
    ib.start = 1'b0; ib.btn = 1'b0; ib.num = 4'd0;
    step(); step();
    chk_zero_a("rst_a");
    chk("rst_b.busy", {7'd0, ib.busy}, 8'd0);
    chk("rst_b.tmo",  {7'd0, ib.timeout_err}, 8'd0);
    rst = 1'b0;
    step();

    // Full round: 1..4 then 5..8
    ia.start = 1'b1; step(); ia.start = 1'b0;
    chk("rnd.busy", {7'd0, ia.busy}, 8'd1);
    chk("rnd.player0", {7'd0, ia.player}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      press_a(4'(i + 1));
      chk("rnd.p1_insere", {7'd0, ia.insere}, 8'd1);
      chk("rnd.p1_num", {4'd0, ia.num_out}, 8'(i + 1));
      chk("rnd.p1_cnt", {5'd0, ia.bet_cnt}, 8'(i + 1));
      step();
      chk("rnd.p1_insere_lo", {7'd0, ia.insere}, 8'd0);
      chk("rnd.p1_fim", {7'd0, ia.fim}, (i == 3) ? 8'd1 : 8'd0);
    end
    step();
    chk("rnd.fim_lo", {7'd0, ia.fim}, 8'd0);
    chk("rnd.player1", {7'd0, ia.player}, 8'd1);
    chk("rnd.cnt_clr", {5'd0, ia.bet_cnt}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      press_a(4'(i + 5));
      chk("rnd.p2_insere", {7'd0, ia.insere}, 8'd1);
      chk("rnd.p2_num", {4'd0, ia.num_out}, 8'(i + 5));
      step();
      chk("rnd.p2_fim", {7'd0, ia.fim}, (i == 3) ? 8'd1 : 8'd0);
    end
    step();
    chk("rnd.fim_jogo", {7'd0, ia.fim_jogo}, 8'd1);
    chk("rnd.busy_done", {7'd0, ia.busy}, 8'd1);
    step();
    chk("rnd.busy_lo", {7'd0, ia.busy}, 8'd0);
    chk("rnd.fim_jogo_lo", {7'd0, ia.fim_jogo}, 8'd0);
    chk("rnd.tmo", {7'd0, ia.timeout_err}, 8'd0);

    // Invalid number, then reset mid-turn of player 2
    ia.start = 1'b1; step(); ia.start = 1'b0;
    press_a(4'd12);
    chk("inv.rej", {7'd0, ia.rej}, 8'd1);
    chk("inv.insere", {7'd0, ia.insere}, 8'd0);
    chk("inv.cnt", {5'd0, ia.bet_cnt}, 8'd0);
    step();
    chk("inv.rej_lo", {7'd0, ia.rej}, 8'd0);
    press_a(4'd9);
    chk("inv.ok_insere", {7'd0, ia.insere}, 8'd1);
    chk("inv.ok_num", {4'd0, ia.num_out}, 8'd9);
    chk("inv.ok_cnt", {5'd0, ia.bet_cnt}, 8'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      press_a(4'd1);
      step();
    end
    chk("inv.fim", {7'd0, ia.fim}, 8'd1);
    step();
    chk("inv.player1", {7'd0, ia.player}, 8'd1);
    press_a(4'd2); step();
    press_a(4'd3);
    chk("mid.insere", {7'd0, ia.insere}, 8'd1);
    chk("mid.cnt", {5'd0, ia.bet_cnt}, 8'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk_zero_a("mid_rst");
    press_a(4'd7);
    chk("mid.no_insere", {7'd0, ia.insere}, 8'd0);
    chk("mid.idle", {7'd0, ia.busy}, 8'd0);
    step();
    chk("mid.no_insere2", {7'd0, ia.insere}, 8'd0);

    // Held button
    ia.start = 1'b1; step(); ia.start = 1'b0;
    ia.btn = 1'b1; ia.num = 4'd3; step();
    chk("held.insere", {7'd0, ia.insere}, 8'd1);
    cnt = 0;
    repeat (49) begin
      step();
      if (ia.insere) cnt++;
    end
    chk("held.extra", 8'(cnt), 8'd0);
    chk("held.cnt", {5'd0, ia.bet_cnt}, 8'd1);
    ia.btn = 1'b0; step();

    // start while busy
    ia.start = 1'b1; step(); ia.start = 1'b0;
    chk("sbusy.busy", {7'd0, ia.busy}, 8'd1);
    chk("sbusy.player", {7'd0, ia.player}, 8'd0);
    chk("sbusy.cnt", {5'd0, ia.bet_cnt}, 8'd1);
    chk("sbusy.fim", {7'd0, ia.fim}, 8'd0);

    // Timeout on dut_b
    ib.start = 1'b1; step(); ib.start = 1'b0;
    chk("tmo.busy", {7'd0, ib.busy}, 8'd1);
    repeat (9) step();
    chk("tmo.fim_early", {7'd0, ib.fim}, 8'd0);
    chk("tmo.err_early", {7'd0, ib.timeout_err}, 8'd0);
    step();
    chk("tmo.fim", {7'd0, ib.fim}, 8'd1);
    chk("tmo.err", {7'd0, ib.timeout_err}, 8'd1);
    step();
    chk("tmo.player1", {7'd0, ib.player}, 8'd1);
    chk("tmo.cnt_clr", {5'd0, ib.bet_cnt}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      press_b(4'(i + 1));
      chk("tmo.p2_insere", {7'd0, ib.insere}, 8'd1);
      step();
    end
    chk("tmo.p2_fim", {7'd0, ib.fim}, 8'd1);
    step();
    chk("tmo.fim_jogo", {7'd0, ib.fim_jogo}, 8'd1);
    chk("tmo.err_done", {7'd0, ib.timeout_err}, 8'd1);
    step();
    chk("tmo.busy_lo", {7'd0, ib.busy}, 8'd0);
    chk("tmo.err_idle", {7'd0, ib.timeout_err}, 8'd1);
    ib.start = 1'b1; step(); ib.start = 1'b0;
    chk("tmo.err_clr", {7'd0, ib.timeout_err}, 8'd0);

    // Edge in the expiry cycle: valid wins, then invalid still times out
    repeat (9) step();
    press_b(4'd5);
    chk("col.insere", {7'd0, ib.insere}, 8'd1);
    chk("col.fim", {7'd0, ib.fim}, 8'd0);
    chk("col.err", {7'd0, ib.timeout_err}, 8'd0);
    step();
    chk("col.fim2", {7'd0, ib.fim}, 8'd0);
    chk("col.err2", {7'd0, ib.timeout_err}, 8'd0);
    repeat (8) step();
    press_b(4'd13);
    chk("col.rej", {7'd0, ib.rej}, 8'd1);
    chk("col.rej_fim", {7'd0, ib.fim}, 8'd1);
    chk("col.rej_err", {7'd0, ib.timeout_err}, 8'd1);
    chk("col.rej_cnt", {5'd0, ib.bet_cnt}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
